// File: rtl/input_pkg.sv
// input_pkg: constants and helpers shared by the pushbutton/switch debounce block.
//   DEBOUNCE_CYCLES_DEFAULT : default stability window in clocks (10 ms at 50 MHz)
//   N_BTN / N_SW            : number of pushbuttons / slide switches
//   SYNC_STAGES             : flops in each input synchroniser
//   N_CH                    : total debounced channels (buttons first, then switches)
package input_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned N_BTN                   = 4;
  localparam int unsigned N_SW                    = 4;
  localparam int unsigned SYNC_STAGES             = 2;
  localparam int unsigned N_CH                    = N_BTN + N_SW;

  // True when exactly one bit of the button vector is set.
  function automatic logic is_onehot(input logic [N_BTN-1:0] v);
    return (v != '0) && ((v & (v - N_BTN'(1))) == '0);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one debounced channel -- synchroniser, stability counter and the
// accepted-level register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : raw input, asynchronous to clk
//   stable      : registered debounced level
//   stable_next : value stable takes on the coming edge (lets the parent register
//                 edge pulses aligned with the level change)
module debounce_bit
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any matching cycle restarts the window; the last mismatching cycle of a full
  // window commits the new level and clears the counter, so it never wraps.
  always_comb begin
    cnt_d       = cnt_q;
    stable_next = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_next = synced;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_next;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/input_debounce.sv
// input_debounce: synchronises and debounces 4 pushbuttons and 4 slide switches.
//   clk, rst_n : board clock, asynchronous active-low reset
//   pushbtns   : raw active-high buttons
//   switches   : raw slide switches
//   btn_level  : debounced button levels
//   btn_pulse  : one-cycle pulse on a debounced button press (0->1)
//   sw_stable  : debounced switch value
//   sw_changed : one-cycle pulse when any debounced switch bit changes
// Build option: define BTN_ONEHOT_EN to suppress button pulses unless the new
// debounced button vector is exactly one-hot (chords never pulse).
module input_debounce
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pushbtns,
  input  logic [N_SW-1:0]  switches,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_stable,
  output logic             sw_changed
);

  logic [N_CH-1:0]  raw_all;
  logic [N_CH-1:0]  stable_all;
  logic [N_CH-1:0]  next_all;
  logic [N_BTN-1:0] btn_stable, btn_next, btn_rise;
  logic [N_SW-1:0]  sw_cur, sw_next;
  logic [N_BTN-1:0] btn_pulse_d;
  logic             sw_changed_d;

  assign raw_all = {switches, pushbtns};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_bit (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (raw_all[i]),
      .stable      (stable_all[i]),
      .stable_next (next_all[i])
    );
  end

  assign btn_stable = stable_all[N_BTN-1:0];
  assign btn_next   = next_all[N_BTN-1:0];
  assign sw_cur     = stable_all[N_CH-1:N_BTN];
  assign sw_next    = next_all[N_CH-1:N_BTN];
  assign btn_rise   = btn_next & ~btn_stable;

  always_comb begin
`ifdef BTN_ONEHOT_EN
    // Downstream decodes buttons with a one-hot case; a chord must not fire.
    btn_pulse_d = is_onehot(btn_next) ? btn_rise : '0;
`else
    btn_pulse_d = btn_rise;
`endif
    sw_changed_d = |(sw_next ^ sw_cur);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pulse  <= '0;
      sw_changed <= 1'b0;
    end else begin
      btn_pulse  <= btn_pulse_d;
      sw_changed <= sw_changed_d;
    end
  end

  assign btn_level = btn_stable;
  assign sw_stable = sw_cur;

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

  localparam int unsigned D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pushbtns = '0;
  logic [3:0] switches = '0;
  logic [3:0] btn_level, btn_pulse, sw_stable;
  logic       sw_changed;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  int pulse_cnt = 0;
  int swch_cnt  = 0;

  input_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pushbtns   (pushbtns),
    .switches   (switches),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a channel accepts the opposite level once the synchronised sample
  // (raw delayed two edges) has disagreed with it on each of the last D edges.
  logic [7:0] raw_pipe[$];
  logic [7:0] win[$];
  logic [7:0] m_stable, s2p, nxt;
  logic [3:0] m_pulse, rise;
  logic       m_swch;
  bit         all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_pipe = {};
      win = {};
      for (int k = 0; k < 2; k++) raw_pipe.push_back(8'h00);
      for (int k = 0; k < int'(D); k++) win.push_back(8'h00);
      m_stable = '0;
      m_pulse  = '0;
      m_swch   = 1'b0;
    end else begin
      s2p = raw_pipe.pop_front();
      raw_pipe.push_back({switches, pushbtns});
      win.push_back(s2p);
      void'(win.pop_front());
      nxt = m_stable;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        foreach (win[j]) if (win[j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_stable[b];
      end
      rise = nxt[3:0] & ~m_stable[3:0];
`ifdef BTN_ONEHOT_EN
      m_pulse = $onehot(nxt[3:0]) ? rise : 4'b0000;
`else
      m_pulse = rise;
`endif
      m_swch   = |(nxt[7:4] ^ m_stable[7:4]);
      m_stable = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", 32'({btn_level, btn_pulse, sw_stable, sw_changed}),
            32'({m_stable[3:0], m_pulse, m_stable[7:4], m_swch}));
    if (btn_pulse != 4'b0000) pulse_cnt++;
    if (sw_changed) swch_cnt++;
  end

  // Edges from the input change (first edge = 1) until the selected event.
  task automatic measure(input int sel, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 0 && btn_pulse != 4'b0000) || (sel == 1 && sw_changed) ||
          (sel == 2 && !btn_level[2])) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int p0, s0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({btn_level, btn_pulse, sw_stable, sw_changed}), 32'h0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single press, held.
    p0 = pulse_cnt;
    pushbtns = 4'b0001;
    measure(0, n);
    check("press_latency", 32'(n), 32'd10);
    check("press_pulse", 32'(btn_pulse), 32'h1);
    check("press_level", 32'(btn_level), 32'h1);
    repeat (20) @(negedge clk);
    check("press_pulse_count", 32'(pulse_cnt - p0), 32'd1);
    pushbtns = 4'b0000;
    repeat (12) @(negedge clk);

    // Bounce: 5 high, 1 low, 5 high, low.
    p0 = pulse_cnt;
    pushbtns[1] = 1'b1;
    repeat (5) @(negedge clk);
    pushbtns[1] = 1'b0;
    @(negedge clk);
    pushbtns[1] = 1'b1;
    repeat (5) @(negedge clk);
    pushbtns[1] = 1'b0;
    repeat (15) @(negedge clk);
    check("bounce_level", 32'(btn_level), 32'h0);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Switch change.
    s0 = swch_cnt;
    switches = 4'b0101;
    measure(1, n);
    check("sw_latency", 32'(n), 32'd10);
    check("sw_value", 32'(sw_stable), 32'h5);
    check("sw_btn_quiet", 32'({btn_level, btn_pulse}), 32'h0);
    repeat (3) @(negedge clk);
    check("sw_change_count", 32'(swch_cnt - s0), 32'd1);

    // Chord of two buttons on one edge.
    p0 = pulse_cnt;
    pushbtns = 4'b0110;
`ifdef BTN_ONEHOT_EN
    repeat (12) @(negedge clk);
    check("chord_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("chord_level", 32'(btn_level), 32'h6);
`else
    measure(0, n);
    check("chord_latency", 32'(n), 32'd10);
    check("chord_pulse", 32'(btn_pulse), 32'h6);
    repeat (3) @(negedge clk);
    check("chord_pulse_count", 32'(pulse_cnt - p0), 32'd1);
`endif
    pushbtns = 4'b0000;
    repeat (12) @(negedge clk);

    // Reset mid-count: window must restart from scratch.
    pushbtns = 4'b1000;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({btn_level, btn_pulse, sw_stable, sw_changed}), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    measure(0, n);
    check("post_reset_latency", 32'(n), 32'd10);
    check("post_reset_pulse", 32'(btn_pulse), 32'h8);
    repeat (3) @(negedge clk);

    // Release produces no pulse.
    pushbtns = 4'b0100;
    repeat (14) @(negedge clk);
    check("rel_setup_level", 32'(btn_level), 32'h4);
    p0 = pulse_cnt;
    pushbtns = 4'b0000;
    measure(2, n);
    check("release_latency", 32'(n), 32'd10);
    repeat (3) @(negedge clk);
    check("release_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
